// File: rtl/rr_lock_arbiter.sv
// rtl/rr_lock_arbiter.sv - wormhole packet arbiter with static/round-robin priority and hold timeout
module rr_lock_arbiter #(
    parameter int IN_N     = 5,
    parameter int HOLD_MAX = 0,
    parameter int CNT_W    = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [IN_N-1:0]          req_i,
    input  logic [IN_N-1:0]          last_i,
    input  logic                     ready_i,
    input  logic                     rr_mode_i,
    output logic [$clog2(IN_N)-1:0]  grant_o,
    output logic [IN_N-1:0]          grant_oh_o,
    output logic                     grant_vld_o,
    output logic                     xfer_o,
    output logic                     timeout_o
);

    localparam int                GW       = $clog2(IN_N);
    localparam logic [GW:0]       N_EXT    = (GW+1)'(IN_N);
    localparam logic [GW-1:0]     LAST_IDX = GW'(IN_N - 1);
    localparam logic [CNT_W-1:0]  HOLD_C   = CNT_W'(HOLD_MAX);
    localparam logic [IN_N-1:0]   OH_ONE   = IN_N'(1);

    typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

    state_t            state_q, state_d;
    logic [GW-1:0]     grant_d;
    logic [IN_N-1:0]   oh_d;
    logic [GW-1:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [GW-1:0]     base;
    logic [GW:0]       idx;
    logic [GW-1:0]     win;
    logic [GW-1:0]     next_ptr;
    logic              sel_last;
    logic              tail_rel;
    logic              hold_hit;

    // Winner search: first requester at or above base, wrapping modulo IN_N.
    // Scanning from the far end down lets the closest hit overwrite later ones.
    always_comb begin
        base = rr_mode_i ? ptr_q : '0;
        win  = '0;
        idx  = '0;
        for (int i = IN_N - 1; i >= 0; i--) begin
            idx = {1'b0, base} + (GW+1)'(i);
            if (idx >= N_EXT) begin
                idx = idx - N_EXT;
            end
            if (req_i[idx[GW-1:0]]) begin
                win = idx[GW-1:0];
            end
        end
    end

    // Transfer / release qualifiers; the one-hot grant masks out non-granted inputs.
    assign grant_vld_o = (state_q == ST_LOCKED);
    assign sel_last    = |(last_i & grant_oh_o);
    assign xfer_o      = grant_vld_o & ready_i & (|(req_i & grant_oh_o));
    assign tail_rel    = xfer_o & sel_last;
    // A tail transfer on the timeout cycle wins, so it is reported as a normal release.
    assign hold_hit    = (HOLD_MAX != 0) && grant_vld_o && (cnt_q == HOLD_C) && !tail_rel;
    assign timeout_o   = hold_hit;
    assign next_ptr    = (grant_o == LAST_IDX) ? '0 : grant_o + GW'(1);

    // Next-state logic: arbitrate in IDLE, hold the lock until tail or timeout.
    always_comb begin
        state_d = state_q;
        grant_d = grant_o;
        oh_d    = grant_oh_o;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (|req_i) begin
                    state_d = ST_LOCKED;
                    grant_d = win;
                    oh_d    = OH_ONE << win;
                end
            end
            ST_LOCKED: begin
                if (tail_rel || hold_hit) begin
                    state_d = ST_IDLE;
                    oh_d    = '0;
                    ptr_d   = next_ptr;
                    cnt_d   = '0;
                end else if (xfer_o) begin
                    cnt_d = '0;
                end else if ((HOLD_MAX != 0) && (cnt_q != HOLD_C)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, grant, pointer and stall counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            grant_o    <= '0;
            grant_oh_o <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_o    <= grant_d;
            grant_oh_o <= oh_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// tb/tb_rr_lock_arbiter.sv - directed scoreboard bench for rr_lock_arbiter
module tb_rr_lock_arbiter;

    localparam int IN_N     = 5;
    localparam int HOLD_MAX = 4;
    localparam int CNT_W    = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [IN_N-1:0]   req;
    logic [IN_N-1:0]   last;
    logic              ready;
    logic              rr_mode;
    logic [2:0]        grant;
    logic [IN_N-1:0]   grant_oh;
    logic              grant_vld;
    logic              xfer;
    logic              timeout;

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_q[$];

    rr_lock_arbiter #(.IN_N(IN_N), .HOLD_MAX(HOLD_MAX), .CNT_W(CNT_W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       (req),
        .last_i      (last),
        .ready_i     (ready),
        .rr_mode_i   (rr_mode),
        .grant_o     (grant),
        .grant_oh_o  (grant_oh),
        .grant_vld_o (grant_vld),
        .xfer_o      (xfer),
        .timeout_o   (timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_grant(input string tag);
        int e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL %s observed=grant_vld=%0b expected=queued grant", tag, grant_vld);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_vld"}, 32'(grant_vld), 32'd1);
            chk({tag, "_idx"}, 32'(grant), 32'(e));
            chk({tag, "_oh"}, 32'(grant_oh), 32'd1 << e);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        last = '0;
        ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // Single-flit packet on input 1, used to position the rr pointer at 2.
    task automatic one_flit_in1();
        req = 5'b00010; last = 5'b00010; ready = 1'b1; rr_mode = 1'b1;
        exp_q.push_back(1);
        tick(); chk_grant("pos_grant");
        tick(); chk("pos_release", 32'(grant_vld), 32'd0);
        req = '0; last = '0;
        tick();
    endtask

    // Three-flit packet on input 2 with all inputs requesting; second flit stalled.
    task automatic pkt3(input bit go_static, input int nxt);
        req = 5'b11111; last = 5'b11011; ready = 1'b1; rr_mode = 1'b1;
        exp_q.push_back(2);
        tick(); chk_grant("t3_lock");
        chk("t3_xfer1", 32'(xfer), 32'd1);
        tick(); ready = 1'b0;
        if (go_static) rr_mode = 1'b0;
        #1;
        chk("t3_stall_xfer", 32'(xfer), 32'd0);
        chk("t3_hold2a", 32'(grant), 32'd2);
        tick(); chk("t3_hold2b", 32'(grant), 32'd2);
        chk("t3_hold_vld", 32'(grant_vld), 32'd1);
        ready = 1'b1; #1;
        chk("t3_xfer2", 32'(xfer), 32'd1);
        tick(); last = 5'b11111; #1;
        chk("t3_tail_xfer", 32'(xfer), 32'd1);
        chk("t3_hold2c", 32'(grant), 32'd2);
        exp_q.push_back(nxt);
        tick(); chk("t3_bubble", 32'(grant_vld), 32'd0);
        tick(); chk_grant("t3_next");
        tick(); chk("t3_next_rel", 32'(grant_vld), 32'd0);
        req = '0; last = '0; rr_mode = 1'b1;
        tick();
    endtask

    initial begin
        rst = 1'b1; req = '0; last = '0; ready = 1'b0; rr_mode = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_vld", 32'(grant_vld), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_oh", 32'(grant_oh), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_xfer", 32'(xfer), 32'd0);

        // 1: static priority, grant one cycle after request
        req = 5'b10110; last = '0; ready = 1'b0; rr_mode = 1'b0;
        exp_q.push_back(1);
        tick(); chk_grant("t1_grant");
        req = 5'b00010; last = 5'b00010; ready = 1'b1; #1;
        chk("t1_xfer", 32'(xfer), 32'd1);
        tick();
        chk("t1_rel_vld", 32'(grant_vld), 32'd0);
        chk("t1_rel_oh", 32'(grant_oh), 32'd0);
        req = '0; last = '0;
        tick();

        // 2: round-robin over single-flit packets with one bubble between grants
        do_reset();
        req = 5'b11111; last = 5'b11111; ready = 1'b1; rr_mode = 1'b1;
        for (int k = 0; k < 6; k++) exp_q.push_back(k % IN_N);
        for (int k = 0; k < 12; k++) begin
            tick();
            if (k % 2 == 0) chk_grant("t2_grant");
            else chk("t2_bubble", 32'(grant_vld), 32'd0);
        end
        req = '0; last = '0;
        tick();

        // 3: locked 3-flit packet, next grant rr then static
        one_flit_in1();
        pkt3(1'b0, 3);
        one_flit_in1();
        pkt3(1'b1, 0);

        // 4: winner drops request without tail -> forced release
        req = 5'b10000; last = '0; ready = 1'b1; rr_mode = 1'b0;
        exp_q.push_back(4);
        tick(); chk_grant("t4_grant");
        req = '0;
        for (int s = 0; s < 3; s++) begin
            tick();
            chk("t4_no_to", 32'(timeout), 32'd0);
            chk("t4_held", 32'(grant_vld), 32'd1);
        end
        tick();
        chk("t4_to_pulse", 32'(timeout), 32'd1);
        tick();
        chk("t4_rel_vld", 32'(grant_vld), 32'd0);
        chk("t4_to_clr", 32'(timeout), 32'd0);
        req = 5'b11111; last = 5'b00001; rr_mode = 1'b1;
        exp_q.push_back(0);
        tick(); chk_grant("t4_next_rr");
        tick(); chk("t4_next_rel", 32'(grant_vld), 32'd0);
        req = '0; last = '0;
        tick();

        // 5: tail transfer coincides with counter at HOLD_MAX
        req = 5'b00100; last = 5'b00100; ready = 1'b0; rr_mode = 1'b1;
        exp_q.push_back(2);
        tick(); chk_grant("t5_grant");
        for (int s = 0; s < 3; s++) begin
            tick();
            chk("t5_no_to", 32'(timeout), 32'd0);
        end
        tick(); ready = 1'b1; #1;
        chk("t5_to_suppr", 32'(timeout), 32'd0);
        chk("t5_tail_xfer", 32'(xfer), 32'd1);
        tick();
        chk("t5_rel_vld", 32'(grant_vld), 32'd0);
        chk("t5_rel_to", 32'(timeout), 32'd0);
        req = '0; last = '0;
        tick();

        // 6: reset mid-packet, arbitration restarts from pointer 0
        req = 5'b01000; last = '0; ready = 1'b1; rr_mode = 1'b1;
        exp_q.push_back(3);
        tick(); chk_grant("t6_grant");
        rst = 1'b1;
        tick();
        chk("t6_rst_vld", 32'(grant_vld), 32'd0);
        chk("t6_rst_grant", 32'(grant), 32'd0);
        chk("t6_rst_oh", 32'(grant_oh), 32'd0);
        chk("t6_rst_to", 32'(timeout), 32'd0);
        rst = 1'b0; req = 5'b11111; last = 5'b11111;
        exp_q.push_back(0);
        tick(); chk_grant("t6_restart");
        tick(); chk("t6_rel", 32'(grant_vld), 32'd0);
        req = '0; last = '0;
        tick();

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
